// File: rtl/lcd_pkg.sv
// Shared definitions for the character LCD controller: HD44780 command bytes,
// control-character codes, FSM state encoding and small helper functions.
`timescale 1ns/1ps
package lcd_pkg;

  // HD44780 command bytes
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_LINE0    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE1    = 8'hC0;  // DDRAM address 0x40

  // Control characters recognised in the byte stream
  localparam logic [7:0] CH_NEWLINE  = 8'h0A;
  localparam logic [7:0] CH_FORMFEED = 8'h0C;

  localparam int unsigned INIT_LEN = 5;
  localparam int unsigned LCD_COLS = 16;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_PWR_WAIT = 3'd0;
  localparam state_t ST_INIT     = 3'd1;
  localparam state_t ST_IDLE     = 3'd2;
  localparam state_t ST_SETUP    = 3'd3;
  localparam state_t ST_EN_HIGH  = 3'd4;
  localparam state_t ST_WAIT     = 3'd5;

  // Power-on command sequence, indexed 0..INIT_LEN-1
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = CMD_FUNC_SET;
      3'd1:    init_cmd = CMD_DISP_ON;
      3'd2:    init_cmd = CMD_CLEAR;
      3'd3:    init_cmd = CMD_ENTRY;
      default: init_cmd = CMD_LINE0;
    endcase
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    max_u = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Synchronous show-ahead byte FIFO with registered dout/full/empty.
// Ports: clock, reset (async, active-high), push/din write side,
//        pop/dout read side (dout valid whenever empty=0), full, empty.
`timescale 1ns/1ps
module lcd_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic [7:0]    dout_q, dout_d;
  logic          push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Next pointers/flags; dout is the head entry after this cycle's push/pop,
  // bypassing din when the write lands on the new head slot.
  always_comb begin
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
    dout_d  = (push_ok && (wr_q == rd_d)) ? din : mem_q[rd_d];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 16x2 character LCD controller fed by the processor's write port.
// Ports: clock, reset (async, active-high); lcd_write/lcd_data byte input
//        (low byte used); lcd_full, lcd_overflow (sticky), lcd_ready status;
//        lcd_en/lcd_rs/lcd_rw/lcd_db LCD bus; lcd_on/lcd_blon tied high.
`timescale 1ns/1ps
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PWR_WAIT_CYC = 750000,
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lcd_write,
  input  logic [31:0] lcd_data,
  output logic        lcd_full,
  output logic        lcd_overflow,
  output logic        lcd_ready,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_db,
  output logic        lcd_on,
  output logic        lcd_blon
);

  localparam int unsigned CNT_MAX = max_u(max_u(PWR_WAIT_CYC, CLR_WAIT_CYC),
                                          max_u(CMD_WAIT_CYC, max_u(SETUP_CYC, EN_CYC)));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic             fifo_full, fifo_empty, pop_c;
  logic [7:0]       fifo_dout;
  logic [23:0]      unused_data;

  state_t           state_q, state_d, ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wait_last_c;
  logic [2:0]       idx_q, idx_d;
  logic             line_q, line_d;
  logic [4:0]       col_q, col_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             clr_q, clr_d;
  logic             pend_q, pend_d, pend_rs_q, pend_rs_d;
  logic [7:0]       pend_db_q, pend_db_d;
  logic             en_q, ovf_q;

  assign unused_data = lcd_data[31:8];

  lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (lcd_write),
    .din   (lcd_data[7:0]),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wait_last_c = clr_q ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);

  // Next-state logic. rs/db only change on entry to SETUP, so they hold
  // through SETUP, EN_HIGH and WAIT. A pending second step (char after a
  // line wrap, or LINE0 after a clear) is issued before returning.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    line_d    = line_q;
    col_d     = col_q;
    rs_d      = rs_q;
    db_d      = db_q;
    clr_d     = clr_q;
    pend_d    = pend_q;
    pend_rs_d = pend_rs_q;
    pend_db_d = pend_db_q;
    pop_c     = 1'b0;

    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == CNT_W'(PWR_WAIT_CYC - 1)) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end

      ST_INIT: begin
        cnt_d = '0;
        if (idx_q == 3'(INIT_LEN)) begin
          state_d = ST_IDLE;
        end else begin
          rs_d    = 1'b0;
          db_d    = init_cmd(idx_q);
          clr_d   = (init_cmd(idx_q) == CMD_CLEAR);
          idx_d   = idx_q + 3'd1;
          ret_d   = ST_INIT;
          state_d = ST_SETUP;
        end
      end

      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          ret_d   = ST_IDLE;
          state_d = ST_SETUP;
          clr_d   = 1'b0;
          rs_d    = 1'b0;
          if (fifo_dout == CH_NEWLINE) begin
            db_d   = line_q ? CMD_LINE0 : CMD_LINE1;
            line_d = ~line_q;
            col_d  = '0;
          end else if (fifo_dout == CH_FORMFEED) begin
            db_d      = CMD_CLEAR;
            clr_d     = 1'b1;
            pend_d    = 1'b1;
            pend_rs_d = 1'b0;
            pend_db_d = CMD_LINE0;
            line_d    = 1'b0;
            col_d     = '0;
          end else if (col_q == 5'(LCD_COLS)) begin
            // Line full: move to the other line first, character follows
            db_d      = line_q ? CMD_LINE0 : CMD_LINE1;
            line_d    = ~line_q;
            pend_d    = 1'b1;
            pend_rs_d = 1'b1;
            pend_db_d = fifo_dout;
            col_d     = 5'd1;
          end else begin
            rs_d  = 1'b1;
            db_d  = fifo_dout;
            col_d = col_q + 5'd1;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = ST_EN_HIGH;
          cnt_d   = '0;
        end
      end

      ST_EN_HIGH: begin
        if (cnt_q == CNT_W'(EN_CYC - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end

      ST_WAIT: begin
        if (cnt_q == wait_last_c) begin
          cnt_d = '0;
          if (pend_q) begin
            rs_d    = pend_rs_q;
            db_d    = pend_db_q;
            clr_d   = 1'b0;
            pend_d  = 1'b0;
            state_d = ST_SETUP;
          end else begin
            state_d = ret_q;
          end
        end
      end

      default: begin
        state_d = ST_PWR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PWR_WAIT;
      ret_q     <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      line_q    <= 1'b0;
      col_q     <= '0;
      rs_q      <= 1'b0;
      db_q      <= '0;
      clr_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_rs_q <= 1'b0;
      pend_db_q <= '0;
      en_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      col_q     <= col_d;
      rs_q      <= rs_d;
      db_q      <= db_d;
      clr_q     <= clr_d;
      pend_q    <= pend_d;
      pend_rs_q <= pend_rs_d;
      pend_db_q <= pend_db_d;
      en_q      <= (state_d == ST_EN_HIGH);
      ovf_q     <= ovf_q | (lcd_write & fifo_full);
    end
  end

  // Ready is a decode of registered state and the registered empty flag
  assign lcd_ready    = (state_q == ST_IDLE) & fifo_empty;
  assign lcd_full     = fifo_full;
  assign lcd_overflow = ovf_q;
  assign lcd_en       = en_q;
  assign lcd_rs       = rs_q;
  assign lcd_db       = db_q;
  assign lcd_rw       = 1'b0;
  assign lcd_on       = 1'b1;
  assign lcd_blon     = 1'b1;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: expected LCD bus transfers are pushed to a
// scoreboard queue as bytes are written and popped as enable pulses appear.
`timescale 1ns/1ps
module tb_lcd_ctrl;

  localparam int unsigned T_PWR   = 10;
  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_EN    = 3;
  localparam int unsigned T_CMD   = 5;
  localparam int unsigned T_CLR   = 9;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lcd_write = 1'b0;
  logic [31:0] lcd_data = '0;
  logic        lcd_full, lcd_overflow, lcd_ready, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;
  logic [7:0]  lcd_db;

  lcd_ctrl #(
    .FIFO_DEPTH   (DEPTH),
    .PWR_WAIT_CYC (T_PWR),
    .SETUP_CYC    (T_SETUP),
    .EN_CYC       (T_EN),
    .CMD_WAIT_CYC (T_CMD),
    .CLR_WAIT_CYC (T_CLR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .lcd_write    (lcd_write),
    .lcd_data     (lcd_data),
    .lcd_full     (lcd_full),
    .lcd_overflow (lcd_overflow),
    .lcd_ready    (lcd_ready),
    .lcd_en       (lcd_en),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_db       (lcd_db),
    .lcd_on       (lcd_on),
    .lcd_blon     (lcd_blon)
  );

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [8:0]  exp_q[$];   // {rs, db}
  logic        m_line = 1'b0;
  logic [4:0]  m_col  = '0;
  logic        last_clear = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the byte stream -> LCD transfers
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0A) begin
      exp_q.push_back({1'b0, (m_line ? 8'h80 : 8'hC0)});
      m_line = ~m_line;
      m_col  = '0;
    end else if (b == 8'h0C) begin
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h080);
      m_line = 1'b0;
      m_col  = '0;
    end else begin
      if (m_col == 5'd16) begin
        exp_q.push_back({1'b0, (m_line ? 8'h80 : 8'hC0)});
        m_line = ~m_line;
        m_col  = '0;
      end
      exp_q.push_back({1'b1, b});
      m_col = m_col + 5'd1;
    end
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h080);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clock);
    lcd_write = 1'b1;
    lcd_data  = {24'hA5A5A5, b};
    model_byte(b);
    @(negedge clock);
    lcd_write = 1'b0;
  endtask

  // Capture one enable pulse; low = en-low samples preceding it
  task automatic get_pulse(output logic ok, output logic [8:0] val, output int unsigned width,
                           output int unsigned low, output logic stable);
    int unsigned n = 0;
    ok = 1'b0; val = '0; width = 0; low = 1; stable = 1'b1;
    forever begin
      @(negedge clock); n++;
      if (lcd_en === 1'b1) break;
      if (n >= TIMEOUT) return;
      low++;
    end
    val   = {lcd_rs, lcd_db};
    width = 1;
    forever begin
      @(negedge clock); n++;
      if (lcd_en !== 1'b1) break;
      if ({lcd_rs, lcd_db} !== val) stable = 1'b0;
      width++;
      if (n >= TIMEOUT) return;
    end
    if ({lcd_rs, lcd_db} !== val) stable = 1'b0;
    ok = 1'b1;
  endtask

  task automatic one_pulse(output logic ok);
    logic [8:0]  val, want;
    int unsigned width, low;
    logic        stable;
    get_pulse(ok, val, width, low, stable);
    check("pulse_seen", 32'(ok), 32'd1);
    if (!ok) return;
    want = exp_q.pop_front();
    check("pulse_rs_db", 32'(val), 32'(want));
    check("en_width", width, T_EN);
    check("bus_stable", 32'(stable), 32'd1);
    if (last_clear) check("clear_gap", 32'(low >= T_CLR), 32'd1);
    last_clear = (val == 9'h001);
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (lcd_ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clock); n++;
    end
    check("ready", 32'(lcd_ready), 32'd1);
  endtask

  task automatic drain();
    logic ok;
    last_clear = 1'b0;
    while (exp_q.size() > 0) begin
      one_pulse(ok);
      if (!ok) exp_q.delete();
    end
    wait_ready();
  endtask

  initial begin
    logic        ok;
    logic [7:0]  b;
    int unsigned n;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_db", 32'(lcd_db), 32'h00);
    check("rst_full", 32'(lcd_full), 32'd0);
    check("rst_ovf", 32'(lcd_overflow), 32'd0);
    check("rst_ready", 32'(lcd_ready), 32'd0);
    check("tie_rw_on_blon", 32'({lcd_rw, lcd_on, lcd_blon}), 32'b011);

    // Power-on init sequence
    reset = 1'b0;
    push_init();
    repeat (4) @(negedge clock);
    check("ready_in_pwr_wait", 32'(lcd_ready), 32'd0);
    drain();

    // Single character
    write_byte(8'h41);
    drain();

    // Form feed: clear then home
    write_byte(8'h0C);
    drain();

    // 17 characters: wrap to line 1 before the last
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(8'h30 + i));
      drain();
    end

    // Back to line 0, then two newlines, then a full line + wrap
    write_byte(8'h0C); drain();
    write_byte(8'h0A); drain();
    write_byte(8'h0A); drain();
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(8'h61 + i));
      drain();
    end

    // Overflow: burst while the clear wait is in progress
    check("ovf_before_burst", 32'(lcd_overflow), 32'd0);
    write_byte(8'h0C);
    last_clear = 1'b0;
    one_pulse(ok);
    last_clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 3) check("full_before_4th", 32'(lcd_full), 32'd0);
      if (i == 4) check("full_after_4th", 32'(lcd_full), 32'd1);
      b = 8'(8'h50 + i);
      lcd_write = 1'b1;
      lcd_data  = {24'h5A5A5A, b};
      if (i < int'(DEPTH)) model_byte(b);
    end
    @(negedge clock);
    lcd_write = 1'b0;
    check("ovf_set", 32'(lcd_overflow), 32'd1);
    check("full_after_burst", 32'(lcd_full), 32'd1);
    while (exp_q.size() > 0) begin
      one_pulse(ok);
      if (!ok) exp_q.delete();
    end
    wait_ready();
    check("full_drained", 32'(lcd_full), 32'd0);
    check("ovf_sticky", 32'(lcd_overflow), 32'd1);

    // Reset in the middle of an enable pulse
    write_byte(8'h42);
    n = 0;
    while (lcd_en !== 1'b1 && n < TIMEOUT) begin
      @(negedge clock); n++;
    end
    check("en_before_reset", 32'(lcd_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_en", 32'(lcd_en), 32'd0);
    check("rst_mid_db", 32'(lcd_db), 32'h00);
    check("rst_mid_ovf", 32'(lcd_overflow), 32'd0);
    check("rst_mid_ready", 32'(lcd_ready), 32'd0);
    exp_q.delete();
    m_line = 1'b0;
    m_col  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    push_init();
    drain();
    write_byte(8'h43);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Consumer end of the processor's character-output port: accepts the one-cycle `lcd_write` strobe plus `lcd_data` word and buffers the low byte in a FIFO.
- Drives an HD44780-compatible 16x2 character LCD: power-on init sequence, enable-pulse timing, per-command wait times, cursor line/column tracking.
- Sits beside the processor at top level, same clock domain.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- PWR_WAIT_CYC, 750000, cycles after reset before the first init command (15 ms @ 50 MHz).
- SETUP_CYC, 4, cycles `lcd_rs`/`lcd_db` are stable before `lcd_en` rises.
- EN_CYC, 25, cycles `lcd_en` is held high.
- CMD_WAIT_CYC, 2000, cycles after `lcd_en` falls for a normal command or character.
- CLR_WAIT_CYC, 82000, cycles after `lcd_en` falls for clear (0x01).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- lcd_write  in  1  one-cycle write strobe from processor
- lcd_data  in  32  write data; bits [7:0] used, [31:8] ignored
- lcd_full  out  1  FIFO full
- lcd_overflow  out  1  sticky: a write was dropped because the FIFO was full
- lcd_ready  out  1  init complete, FSM in IDLE, FIFO empty
- lcd_en  out  1  LCD enable
- lcd_rs  out  1  LCD register select: 0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_db  out  8  LCD data bus
- lcd_on  out  1  constant 1
- lcd_blon  out  1  constant 1

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high; it clears everything immediately, including mid-pulse.
- Reset values: `lcd_en`=0, `lcd_rs`=0, `lcd_db`=0x00, `lcd_full`=0, `lcd_overflow`=0, `lcd_ready`=0; FIFO empty; col=0, line=0; state PWR_WAIT.
- Write side:
  - `lcd_write` is sampled on the rising edge.
  - If not full, push `lcd_data[7:0]`.
  - If full, drop the byte and set `lcd_overflow`.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - `lcd_full` is registered and updates the cycle after the push.
- States:
  - PWR_WAIT: count PWR_WAIT_CYC, then go to INIT.
  - INIT: issue commands 0x38, 0x0C, 0x01, 0x06, 0x80 in order through the byte-issue sequence. 0x01 uses CLR_WAIT_CYC; the others use CMD_WAIT_CYC. Then go to IDLE.
  - IDLE: if the FIFO is not empty, pop one byte and classify it:
    - 0x0A (newline): command 0x80 | (line ? 0x00 : 0x40); toggle line; col=0.
    - 0x0C (form feed): command 0x01, then 0x80; line=0, col=0.
    - Other bytes when col==16: first issue a line-change command as for 0x0A, then the character. The character is not lost.
    - Other bytes: data write (`lcd_rs`=1), then col+1.
  - Byte-issue sequence: SETUP (SETUP_CYC) -> EN_HIGH (EN_CYC, `lcd_en`=1) -> WAIT (CMD_WAIT_CYC or CLR_WAIT_CYC) -> return.
    - Return target is INIT with the next index, IDLE, or the pending second step (char after wrap, 0x80 after clear).
    - `lcd_rs`/`lcd_db` stay stable from SETUP entry through the end of WAIT.
- Status and timing:
  - `lcd_ready` is high only in IDLE with the FIFO empty.
  - Pops occur only in IDLE, at most one per byte-issue sequence.
  - Wait counters are wide enough for the largest parameter.
- Overflow: `lcd_overflow` is cleared only by reset.

Decomposition:
- Package `lcd_pkg`: command constants (FUNC_SET=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY=0x06, LINE0=0x80, LINE1=0xC0), control-character codes (0x0A, 0x0C), FSM state enum.
- One sub-module: `lcd_fifo`, a synchronous FIFO.
  - Ports: clock, reset, push, din[7:0], pop, dout[7:0], full, empty.
  - Registered outputs; `dout` is valid whenever `empty`=0 (show-ahead).

Test Plan (bench overrides: PWR_WAIT_CYC=10, SETUP_CYC=2, EN_CYC=3, CMD_WAIT_CYC=5, CLR_WAIT_CYC=9, FIFO_DEPTH=4):
- Reset release, no writes -> `lcd_en` pulses carry `lcd_db` 0x38, 0x0C, 0x01, 0x06, 0x80 with `lcd_rs`=0. Each pulse is 3 cycles high; the gap after 0x01 is >=9 cycles. `lcd_ready`=1 afterwards.
- After init, write 0x41 -> one pulse with `lcd_rs`=1, `lcd_db`=0x41; `lcd_ready` returns to 1.
- 17 writes of 0x30..0x40 -> 16 data pulses, then command 0xC0, then data 0x40.
- Write 0x0A, then 0x0A -> commands 0xC0, then 0x80; the next character lands at col 0.
- Write 0x0C -> command 0x01 with >=9-cycle wait, then 0x80.
- Six back-to-back writes while busy after init -> `lcd_full`=1 after the 4th (pushes only; one-cycle flag delay). Extra writes are dropped and `lcd_overflow`=1. Exactly 4 data pulses follow.
- Assert reset during EN_HIGH -> `lcd_en`=0 immediately; init sequence restarts from PWR_WAIT.
